alu_stream_fifo: RTL and testbench

Parametrised, clocked successor to the combinational ALU. Operand pairs and opcodes enter through a valid/ready handshake. Each accepted operation is evaluated and its result and flags are written into a DEPTH-entry result FIFO. Results are drained in order through a second valid/ready handshake. The block sits between a command source and a result consumer, and absorbs consumer back-pressure.

---
 rtl/alu_stream_fifo_if.sv | 31 +++
 rtl/alu_stream_fifo.sv | 103 ++++++++++
 tb/tb_alu_stream_fifo.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_stream_fifo_if.sv
// rtl/alu_stream_fifo_if.sv - command and result handshake bundle for alu_stream_fifo
interface alu_stream_fifo_if #(
  parameter int W = 4
);
  // command stream
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  // result stream
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_sign;
  logic         out_carr;
  logic         out_zero;
  logic         out_ill;

  // command source and result consumer side
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_res, out_sign, out_carr, out_zero, out_ill
  );

  // ALU / FIFO side
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_res, out_sign, out_carr, out_zero, out_ill
  );
endinterface

// File: rtl/alu_stream_fifo.sv
// rtl/alu_stream_fifo.sv - clocked ALU feeding a DEPTH-entry in-order result FIFO
module alu_stream_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  alu_stream_fifo_if.slave s,
  output logic [CW-1:0]    count,
  output logic             err_sticky,
  input  logic             err_clr
);
  // entry layout: {res, sign, carr, zero, ill}
  localparam int EW = W + 4;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [W:0]   y;
  logic [W-1:0] prod;
  logic         f_sign;
  logic         f_carr;
  logic         f_zero;
  logic         f_ill;
  logic         push;
  logic         pop;
  logic [EW-1:0] head;

  // in_ready depends on registered occupancy only, so a pop never opens a slot the same cycle
  assign s.in_ready  = (count < CW'(DEPTH));
  assign s.out_valid = (count != '0);
  assign push        = s.in_valid && s.in_ready;
  assign pop         = s.out_valid && s.out_ready;

  // evaluate the offered command; y keeps the carry bit so zero sees all W+1 bits
  always_comb begin
    y      = '0;
    prod   = '0;
    f_sign = 1'b0;
    f_carr = 1'b0;
    f_ill  = 1'b0;
    case (s.in_op)
      4'b1101: begin
        y      = {1'b0, s.in_a} + {1'b0, s.in_b};
        f_carr = y[W];
      end
      4'b1001: y = {1'b0, s.in_a & s.in_b};
      4'b0101: begin
        prod = {{(W/2){1'b0}}, s.in_a[W/2-1:0]} * {{(W/2){1'b0}}, s.in_b[W/2-1:0]};
        y    = {1'b0, prod};
      end
      4'b0001: y = {1'b0, ~s.in_a};
      4'b1100: y = {1'b0, ~(s.in_a & s.in_b)};
      4'b0010: begin
        if (s.in_b > s.in_a) begin
          y      = {1'b0, s.in_b - s.in_a};
          f_sign = 1'b1;
        end else begin
          y      = {1'b0, s.in_a - s.in_b};
        end
      end
      4'b0011: y = {1'b0, ~(s.in_a ^ s.in_b)};
      4'b0110: y = {1'b0, ~(s.in_a | s.in_b)};
      default: f_ill = 1'b1;
    endcase
    f_zero = (y == '0);
  end

  // storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {y[W-1:0], f_sign, f_carr, f_zero, f_ill};
  end

  // pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // sticky illegal-opcode flag; a fresh illegal accept beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 err_sticky <= 1'b0;
    else if (push && f_ill)  err_sticky <= 1'b1;
    else if (err_clr)        err_sticky <= 1'b0;
  end

  // head fields are masked to zero whenever nothing is queued
  always_comb begin
    head = s.out_valid ? mem[rd_ptr] : '0;
    {s.out_res, s.out_sign, s.out_carr, s.out_zero, s.out_ill} = head;
  end
endmodule

// File: tb/tb_alu_stream_fifo.sv
// tb/tb_alu_stream_fifo.sv - randomized and directed bench for alu_stream_fifo
module tb_alu_stream_fifo;
  localparam int W     = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0] res;
    logic       sign;
    logic       carr;
    logic       zero;
    logic       ill;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       err_clr = 1'b0;
  logic [2:0] count;
  logic       err_sticky;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  logic m_err = 1'b0;

  alu_stream_fifo_if #(.W(W)) bus ();

  alu_stream_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (bus.slave),
    .count      (count),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  // reference: plain integer arithmetic on the opcode rules
  function automatic ent_t model(input logic [3:0] op, input int a, input int b);
    ent_t e;
    int   y;
    e = '0;
    y = 0;
    case (op)
      4'b1101: begin y = a + b; e.carr = (y > 15); end
      4'b1001: y = a & b;
      4'b0101: y = (a % 4) * (b % 4);
      4'b0001: y = 15 - a;
      4'b1100: y = 15 - (a & b);
      4'b0010: begin
        if (b > a) begin y = b - a; e.sign = 1'b1; end
        else y = a - b;
      end
      4'b0011: y = 15 - (a ^ b);
      4'b0110: y = 15 - (a | b);
      default: begin y = 0; e.ill = 1'b1; end
    endcase
    e.res  = 4'(y % 16);
    e.zero = (y == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] head_bits();
    return {24'd0, bus.out_res, bus.out_sign, bus.out_carr, bus.out_zero, bus.out_ill};
  endfunction

  // one clock of model/DUT comparison; entered and left at posedge+1
  task automatic tick();
    ent_t e;
    logic acc;
    logic pp;
    e = '0;
    if (q.size() > 0) begin
      chk("out_valid", bus.out_valid, 1);
      chk("head", head_bits(), {24'd0, q[0]});
    end else begin
      chk("out_valid", bus.out_valid, 0);
      chk("head_idle", head_bits(), 0);
    end
    chk("in_ready", bus.in_ready, q.size() < DEPTH);
    acc = bus.in_valid && (q.size() < DEPTH);
    pp  = bus.out_ready && (q.size() > 0);
    if (acc) e = model(bus.in_op, int'(bus.in_a), int'(bus.in_b));
    @(posedge clk);
    #1;
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(e);
    if (acc && e.ill) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    chk("count", count, q.size());
    chk("err_sticky", err_sticky, m_err);
  endtask

  task automatic set_cmd(input logic v, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  task automatic rand_cmd();
    set_cmd(1'b1, 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  // push one command into an empty FIFO, compare head with fixed values, then pop it
  task automatic one_op(input string tag, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp);
    bus.out_ready = 1'b0;
    set_cmd(1'b1, op, a, b);
    tick();
    bus.in_valid = 1'b0;
    chk(tag, head_bits(), {24'd0, exp});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    set_cmd(1'b0, 4'd0, 4'd0, 4'd0);
    bus.out_ready = 1'b0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_head", head_bits(), 0);
    chk("rst_err", err_sticky, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // directed arithmetic: {res, sign, carr, zero, ill}
    one_op("add_f_1", 4'b1101, 4'hF, 4'h1, {4'h0, 4'b0100});
    one_op("add_0_0", 4'b1101, 4'h0, 4'h0, {4'h0, 4'b0010});
    one_op("add_7_8", 4'b1101, 4'h7, 4'h8, {4'hF, 4'b0000});
    one_op("sub_3_5", 4'b0010, 4'h3, 4'h5, {4'h2, 4'b1000});
    one_op("sub_5_3", 4'b0010, 4'h5, 4'h3, {4'h2, 4'b0000});
    one_op("sub_7_7", 4'b0010, 4'h7, 4'h7, {4'h0, 4'b0010});
    one_op("mul_b_6", 4'b0101, 4'hB, 4'h6, {4'h6, 4'b0000});
    one_op("not_5",   4'b0001, 4'h5, 4'h0, {4'hA, 4'b0000});
    one_op("xnor_ca", 4'b0011, 4'hC, 4'hA, {4'h9, 4'b0000});
    one_op("nor_0_0", 4'b0110, 4'h0, 4'h0, {4'hF, 4'b0000});
    one_op("nand_ff", 4'b1100, 4'hF, 4'hF, {4'h0, 4'b0010});
    one_op("and_c_6", 4'b1001, 4'hC, 4'h6, {4'h4, 4'b0000});

    // illegal opcode and sticky error
    one_op("ill_0000", 4'b0000, 4'h5, 4'h3, {4'h0, 4'b0011});
    chk("err_set", err_sticky, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr_alone", err_sticky, 0);
    set_cmd(1'b1, 4'b1111, 4'h1, 4'h2);
    err_clr = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    err_clr = 1'b0;
    bus.in_valid = 1'b0;
    chk("err_set_wins", err_sticky, 1);
    tick();

    // back-pressure: fill, hold a fifth command, then drain in order
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin rand_cmd(); tick(); end
    chk("full_count", count, DEPTH);
    chk("full_in_ready", bus.in_ready, 0);
    set_cmd(1'b1, 4'b1101, 4'h3, 4'h4);
    tick();
    tick();
    bus.out_ready = 1'b1;
    tick();
    chk("full_pop_no_push", count, DEPTH - 1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    chk("drained", count, 0);

    // simultaneous push and pop at count 2
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_cmd(); tick(); end
    bus.out_ready = 1'b1;
    rand_cmd();
    tick();
    chk("pushpop_count2", count, 2);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // empty boundary with a coincident push keeps out_valid high
    bus.out_ready = 1'b0;
    rand_cmd();
    tick();
    bus.out_ready = 1'b1;
    rand_cmd();
    tick();
    chk("empty_push_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    tick();

    // repeated fill/drain for pointer wrap
    for (int r = 0; r < 10; r++) begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin rand_cmd(); tick(); end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) tick();
    end

    // random traffic
    for (int i = 0; i < 300; i++) begin
      set_cmd(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      err_clr       = ($urandom_range(0, 7) == 0);
      tick();
    end
    err_clr = 1'b0;

    // mid-cycle reset with three entries queued
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    tick();
    while (q.size() > 0) begin bus.out_ready = 1'b1; tick(); end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_cmd(); tick(); end
    bus.in_valid = 1'b0;
    chk("pre_rst_count", count, 3);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_count", count, 0);
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_in_ready", bus.in_ready, 1);
    q.delete();
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    set_cmd(1'b1, 4'b1101, 4'h2, 4'h3);
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_res", bus.out_res, 5);
    bus.out_ready = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
